// File: rtl/clint_irq_source.sv
// Machine-mode interrupt source: MSIP / MTIME / MTIMECMP behind a two-cycle bus slave,
// with registered timer/soft/ext interrupt levels and one-cycle clear pulses on their falling edges.
//
// state | meaning
// IDLE  | no access in flight; busy follows ren|wen, rdata is 0
// RESP  | access accepted; rdata shows the addressed register, a write commits on exit
module clint_irq_source #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ren,
  input  logic        wen,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  input  logic        ext_irq,
  output logic        timer_int,
  output logic        soft_int,
  output logic        ext_int,
  output logic        timer_int_clear,
  output logic        soft_int_clear,
  output logic        ext_int_clear
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state;
  logic          wr_pend;
  logic          msip;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic [PW-1:0] presc;
  logic          tick;
  logic          in_win;
  logic          sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
  logic          wr_en;
  logic [31:0]   rd_val;
  logic          ext_s1, ext_s2;
  logic          timer_d, soft_d, ext_d;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    return res;
  endfunction

  assign in_win      = (addr[31:16] == BASE_ADDR[31:16]);
  assign sel_msip    = in_win && (addr[15:0] == 16'h0000);
  assign sel_cmp_lo  = in_win && (addr[15:0] == 16'h4000);
  assign sel_cmp_hi  = in_win && (addr[15:0] == 16'h4004);
  assign sel_time_lo = in_win && (addr[15:0] == 16'hBFF8);
  assign sel_time_hi = in_win && (addr[15:0] == 16'hBFFC);

  // The master holds addr/wdata/byte_en until busy drops, so RESP uses them live.
  assign wr_en = (state == RESP) && wr_pend;
  assign busy  = (state == IDLE) && (ren || wen);
  assign tick  = (presc == PS_LAST);

  always_comb begin
    rd_val = 32'h0;
    if (sel_msip)         rd_val = {31'h0, msip};
    else if (sel_cmp_lo)  rd_val = mtimecmp[31:0];
    else if (sel_cmp_hi)  rd_val = mtimecmp[63:32];
    else if (sel_time_lo) rd_val = mtime[31:0];
    else if (sel_time_hi) rd_val = mtime[63:32];
  end

  assign rdata = (state == RESP) ? rd_val : 32'h0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      wr_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ren || wen) begin
          state   <= RESP;
          wr_pend <= wen;
        end
        RESP: begin
          state   <= IDLE;
          wr_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      msip     <= 1'b0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (wr_en) begin
      if (sel_msip && byte_en[0]) msip <= wdata[0];
      if (sel_cmp_lo) mtimecmp[31:0]  <= merge(mtimecmp[31:0], wdata, byte_en);
      if (sel_cmp_hi) mtimecmp[63:32] <= merge(mtimecmp[63:32], wdata, byte_en);
    end
  end

  // A bus write to MTIME suppresses that cycle's increment; the other half holds.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      presc <= '0;
      mtime <= 64'h0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (wr_en && sel_time_lo)      mtime[31:0]  <= merge(mtime[31:0], wdata, byte_en);
      else if (wr_en && sel_time_hi) mtime[63:32] <= merge(mtime[63:32], wdata, byte_en);
      else if (tick)                 mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ext_s1          <= 1'b0;
      ext_s2          <= 1'b0;
      timer_int       <= 1'b0;
      soft_int        <= 1'b0;
      ext_int         <= 1'b0;
      timer_d         <= 1'b0;
      soft_d          <= 1'b0;
      ext_d           <= 1'b0;
      timer_int_clear <= 1'b0;
      soft_int_clear  <= 1'b0;
      ext_int_clear   <= 1'b0;
    end else begin
      ext_s1          <= ext_irq;
      ext_s2          <= ext_s1;
      timer_int       <= (mtime >= mtimecmp);
      soft_int        <= msip;
      ext_int         <= ext_s2;
      timer_d         <= timer_int;
      soft_d          <= soft_int;
      ext_d           <= ext_int;
      // Pulse lands in the cycle after the level has been low for one cycle.
      timer_int_clear <= timer_d & ~timer_int;
      soft_int_clear  <= soft_d & ~soft_int;
      ext_int_clear   <= ext_d & ~ext_int;
    end
  end

endmodule

// File: tb/tb_clint_irq_source.sv
// Directed bench for clint_irq_source: a register-access vector table plus hand sequences
// for interrupt timing, MTIME carry/priority and reset during an access.
module tb_clint_irq_source;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] addr, wdata, rdata;
  logic        ren, wen, busy, ext_irq;
  logic [3:0]  byte_en;
  logic        timer_int, soft_int, ext_int;
  logic        timer_int_clear, soft_int_clear, ext_int_clear;

  int total = 0;
  int bad   = 0;

  clint_irq_source dut (
    .CLK(CLK), .nRST(nRST), .addr(addr), .wdata(wdata), .ren(ren), .wen(wen),
    .byte_en(byte_en), .rdata(rdata), .busy(busy), .ext_irq(ext_irq),
    .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
    .timer_int_clear(timer_int_clear), .soft_int_clear(soft_int_clear),
    .ext_int_clear(ext_int_clear)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, output logic [31:0] rd_data);
    @(posedge CLK); #1;
    wen = wr; ren = rd; addr = a; wdata = d; byte_en = be;
    @(negedge CLK);
    chk("busy_idle", busy, 1);
    chk("rdata_idle", rdata, 0);
    @(negedge CLK);
    chk("busy_resp", busy, 0);
    rd_data = rdata;
    @(posedge CLK); #1;
    wen = 1'b0; ren = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    vecs[0]  = '{1'b0, 1'b1, 32'h0200_4000, 32'h0,         4'hF, 32'hFFFF_FFFF};
    vecs[1]  = '{1'b0, 1'b1, 32'h0200_4004, 32'h0,         4'hF, 32'hFFFF_FFFF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0200_0000, 32'h0,         4'hF, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0200_4000, 32'hAABB_CCDD, 4'h1, 32'hFFFF_FFFF};
    vecs[4]  = '{1'b0, 1'b1, 32'h0200_4000, 32'h0,         4'hF, 32'hFFFF_FFDD};
    vecs[5]  = '{1'b1, 1'b0, 32'h0200_4000, 32'h1234_5678, 4'h6, 32'hFFFF_FFDD};
    vecs[6]  = '{1'b0, 1'b1, 32'h0200_4000, 32'h0,         4'hF, 32'hFF34_56DD};
    vecs[7]  = '{1'b0, 1'b1, 32'h0200_8000, 32'h0,         4'hF, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0200_8000, 32'h1,         4'hF, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0300_0000, 32'h0,         4'hF, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h0300_0000, 32'h1,         4'hF, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'h0200_0000, 32'h0,         4'hF, 32'h0};
    vecs[12] = '{1'b1, 1'b1, 32'h0200_0000, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 32'h0200_0000, 32'h0,         4'hF, 32'h1};
    vecs[14] = '{1'b1, 1'b0, 32'h0200_0000, 32'h0,         4'hE, 32'h1};
    vecs[15] = '{1'b0, 1'b1, 32'h0200_0000, 32'h0,         4'hF, 32'h1};
    vecs[16] = '{1'b1, 1'b0, 32'h0200_0000, 32'h0,         4'hF, 32'h1};
    vecs[17] = '{1'b0, 1'b1, 32'h0200_0000, 32'h0,         4'hF, 32'h0};
    vecs[18] = '{1'b1, 1'b0, 32'h0200_4000, 32'hFFFF_FFFF, 4'hF, 32'hFF34_56DD};

    nRST = 1'b0; ren = 1'b0; wen = 1'b0; addr = 32'h0; wdata = 32'h0; byte_en = 4'h0;
    ext_irq = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_timer", timer_int, 0);
    chk("rst_soft", soft_int, 0);
    chk("rst_ext", ext_int, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    for (int i = 0; i < 19; i++) begin
      bus(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d, vecs[i].be, r);
      chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp);
    end

    // soft interrupt set / clear
    repeat (4) @(posedge CLK);
    bus(1'b1, 1'b0, 32'h0200_0000, 32'h1, 4'hF, r);
    @(negedge CLK);
    chk("soft_before", soft_int, 0);
    @(posedge CLK); @(negedge CLK);
    chk("soft_set", soft_int, 1);
    bus(1'b1, 1'b0, 32'h0200_0000, 32'h0, 4'hF, r);
    @(negedge CLK);
    chk("soft_hold", soft_int, 1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge CLK); @(negedge CLK);
      chk($sformatf("soft_low_%0d", i), soft_int, 0);
      chk($sformatf("soft_clr_%0d", i), soft_int_clear, (i == 2));
    end

    // timer: cmp = 20 with MTIME restarted from 0
    bus(1'b1, 1'b0, 32'h0200_4000, 32'd20, 4'hF, r);
    bus(1'b1, 1'b0, 32'h0200_BFF8, 32'h0, 4'hF, r);
    bus(1'b1, 1'b0, 32'h0200_4004, 32'h0, 4'hF, r);
    for (int i = 1; i <= 18; i++) begin
      @(posedge CLK); @(negedge CLK);
      chk($sformatf("timer_rise_%0d", i), timer_int, (i == 18));
    end
    bus(1'b1, 1'b0, 32'h0200_4004, 32'hFFFF_FFFF, 4'hF, r);
    @(negedge CLK);
    chk("timer_hold", timer_int, 1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge CLK); @(negedge CLK);
      chk($sformatf("timer_low_%0d", i), timer_int, 0);
      chk($sformatf("timer_clr_%0d", i), timer_int_clear, (i == 2));
    end

    // MTIME low-half carry and write priority over increment
    bus(1'b1, 1'b0, 32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, r);
    bus(1'b0, 1'b1, 32'h0200_BFF8, 32'h0, 4'hF, r);
    chk("mtime_lo_wrap", r, 32'h1);
    bus(1'b0, 1'b1, 32'h0200_BFFC, 32'h0, 4'hF, r);
    chk("mtime_hi_carry", r, 32'h1);
    bus(1'b1, 1'b0, 32'h0200_BFF8, 32'h0000_1000, 4'hF, r);
    bus(1'b0, 1'b1, 32'h0200_BFF8, 32'h0, 4'hF, r);
    chk("mtime_wr_prio", r, 32'h0000_1002);
    chk("timer_no_fire", timer_int, 0);

    // external interrupt through the synchronizer
    @(posedge CLK); #1;
    ext_irq = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge CLK); @(negedge CLK);
      chk($sformatf("ext_rise_%0d", i), ext_int, (i == 3));
      chk($sformatf("ext_noclr_%0d", i), ext_int_clear, 0);
    end
    @(posedge CLK); #1;
    ext_irq = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge CLK); @(negedge CLK);
      chk($sformatf("ext_fall_%0d", i), ext_int, (i < 3));
      chk($sformatf("ext_clr_%0d", i), ext_int_clear, (i == 4));
    end

    // reset in the middle of an MSIP write loses the write
    @(posedge CLK); #1;
    wen = 1'b1; ren = 1'b0; addr = 32'h0200_0000; wdata = 32'h1; byte_en = 4'hF;
    @(posedge CLK); #1;
    nRST = 1'b0;
    #2;
    wen = 1'b0;
    @(negedge CLK);
    chk("midrst_busy", busy, 0);
    chk("midrst_rdata", rdata, 0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    bus(1'b0, 1'b1, 32'h0200_0000, 32'h0, 4'hF, r);
    chk("midrst_msip", r, 32'h0);
    bus(1'b0, 1'b1, 32'h0200_4000, 32'h0, 4'hF, r);
    chk("midrst_cmp_lo", r, 32'hFFFF_FFFF);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("midrst_soft", soft_int, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
